seq_pattern_tx: RTL and testbench
=================================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4, meaning pattern length in bits (2..16).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning width of the repeat and gap counts.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request transmission; sampled only in IDLE.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the current transmission.
REQ-007 The block SHALL have port pattern, input, PAT_W bits: bit pattern, sent MSB first.
REQ-008 The block SHALL have port repeat_n, input, CNT_W bits: number of pattern repetitions.
REQ-009 The block SHALL have port gap, input, CNT_W bits: idle (x=0) cycles between repetitions.
REQ-010 The block SHALL have port x, output, 1 bit: serial data out.
REQ-011 The block SHALL have port bit_valid, output, 1 bit: x carries a pattern bit this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when all repetitions complete.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, GAP and DONE.
REQ-015 In IDLE, start=1 at edge k SHALL capture pattern, repeat_n and gap into internal registers; the FSM SHALL enter SEND after edge k, or DONE if repeat_n==0.
REQ-016 In SEND, x SHALL equal the current pattern bit, MSB first, one bit per cycle for PAT_W cycles, with bit_valid=1; the first bit SHALL appear in the cycle immediately after edge k.
REQ-017 After the last bit of a repetition, the remaining count SHALL decrement: 0 -> DONE; gap==0 -> SEND (back-to-back, no idle cycle); otherwise -> GAP.
REQ-018 In GAP, x=0 and bit_valid=0 for exactly gap cycles, then SEND with the shift register reloaded from the captured pattern.
REQ-019 In DONE, done=1 for exactly one cycle, then IDLE.
REQ-020 In IDLE, GAP and DONE, x SHALL be 0 and bit_valid SHALL be 0.
REQ-021 busy SHALL be 1 in SEND, GAP and DONE, and 0 in IDLE.
REQ-022 start asserted while busy=1 SHALL be ignored.
REQ-023 Input changes while busy=1 SHALL NOT affect the transmission in progress.
REQ-024 stop=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse; stop has priority over all other transitions.
REQ-025 stop and start asserted together in IDLE SHALL be resolved with stop winning, so the FSM stays in IDLE.
REQ-026 Counters SHALL be unsigned and SHALL never wrap: repeat_n = 2^CNT_W-1 sends exactly that many repetitions.
REQ-027 All outputs SHALL be driven from flops or from state-decoded flops, with no combinational path from inputs.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, x=0, bit_valid=0, busy=0, done=0, and clear all counters and the shift register.
REQ-029 Reset asserted mid-SEND SHALL truncate the frame, and no done pulse SHALL follow.
REQ-030 After reset deasserts, the block SHALL accept start on the first clock edge.

Structure
REQ-031 The package seq_tx_pkg SHALL hold the state enum (IDLE, SEND, GAP, DONE) and default PAT_W/CNT_W constants.
REQ-032 The sub-module seq_tx_shift SHALL implement the PAT_W-bit loadable left-shift register plus bit-index counter and SHALL raise a last_bit flag.
REQ-033 The top level SHALL contain the FSM, the repeat counter and the gap counter.

Verification
REQ-034 Bench scenario, back-to-back: pattern=1010, repeat_n=3, gap=0, start pulse -> x = 1,0,1,0,1,0,1,0,1,0,1,0 over 12 consecutive cycles with bit_valid=1; done=1 in cycle 13; busy=0 from cycle 14.
REQ-035 Bench scenario, gaps: pattern=1101, repeat_n=2, gap=2 -> x = 1,1,0,1,0,0,1,1,0,1; bit_valid=0 only in cycles 5-6; then one done pulse.
REQ-036 Bench scenario, zero repeats: repeat_n=0, start -> no bit_valid ever; done=1 exactly one cycle after the start edge; busy=1 for that single cycle.
REQ-037 Bench scenario, abort: stop=1 during the 3rd bit of repetition 2 of 3 -> IDLE next edge, x=0, busy=0, no done pulse; a new start is then accepted.
REQ-038 Bench scenario, ignored inputs: start pulse and pattern change while busy -> the output stream is identical to the undisturbed run.
REQ-039 Bench scenario, async reset mid-GAP (between clock edges) -> all outputs 0 immediately; FSM in IDLE; no done pulse.

Source files
------------

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
package seq_tx_pkg;
    localparam int DEF_PAT_W = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/configuration inputs and serial outputs of the pattern transmitter.
interface seq_pattern_tx_if
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) ();
    logic             start;
    logic             stop;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic [CNT_W-1:0] gap;
    logic             x;
    logic             bit_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, pattern, repeat_n, gap,
        input  x, bit_valid, busy, done
    );

    modport slave (
        input  start, stop, pattern, repeat_n, gap,
        output x, bit_valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx_shift.sv
// Loadable MSB-first shift register with bit index; last_bit marks the final bit of a pattern.
module seq_tx_shift
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] load_val,
    output logic             msb,
    output logic             last_bit
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

    logic [PAT_W-1:0] sreg;
    logic [IDX_W-1:0] idx;

    // load wins over shift so a back-to-back repetition restarts cleanly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
        end else if (load) begin
            sreg <= load_val;
            idx  <= '0;
        end else if (shift) begin
            sreg <= {sreg[PAT_W-2:0], 1'b0};
            idx  <= last_bit ? '0 : idx + IDX_W'(1);
        end
    end

    assign msb      = sreg[PAT_W-1];
    assign last_bit = (idx == LAST_IDX);
endmodule

// File: rtl/seq_pattern_tx.sv
// Sends a captured bit pattern repeat_n times, MSB first, with gap idle cycles between repetitions.
// Outputs are decoded from the state register and shift register only.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);
    state_t           state, next_state;
    logic             msb, last_bit, load, shift, start_acc, last_rep;
    logic [PAT_W-1:0] pat_r, load_val;
    logic [CNT_W-1:0] rem_r, gap_r, gap_cnt;

    assign start_acc = (state == IDLE) && bus.start && !bus.stop;
    assign last_rep  = (rem_r == CNT_W'(1));
    // on the start edge the captured copy is not yet valid, so load straight from the port
    assign load_val  = (state == IDLE) ? bus.pattern : pat_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (bus.stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) next_state = (bus.repeat_n == '0) ? DONE : SEND;
                SEND: if (last_bit) begin
                    if (last_rep)         next_state = DONE;
                    else if (gap_r == '0) next_state = SEND;
                    else                  next_state = GAP;
                end
                GAP:  if (gap_cnt == '0) next_state = SEND;
                DONE: next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.x         = (state == SEND) && msb;
        bus.bit_valid = (state == SEND);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        shift         = (state == SEND);
        load          = (next_state == SEND) && ((state != SEND) || last_bit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r   <= '0;
            rem_r   <= '0;
            gap_r   <= '0;
            gap_cnt <= '0;
        end else begin
            if (start_acc) begin
                pat_r <= bus.pattern;
                rem_r <= bus.repeat_n;
                gap_r <= bus.gap;
            end
            // rem_r is at least 1 whenever SEND is active, so this never underflows
            if (state == SEND && last_bit && !bus.stop)
                rem_r <= rem_r - CNT_W'(1);
            if (state == SEND && next_state == GAP)
                gap_cnt <= gap_r - CNT_W'(1);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - CNT_W'(1);
        end
    end

    seq_tx_shift #(.PAT_W(PAT_W)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_val (load_val),
        .msb      (msb),
        .last_bit (last_bit)
    );
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle output streams compared against hand-computed vectors.
module tb_seq_pattern_tx;
    logic        clk;
    logic        reset;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] xs, vs, ds, bs;
    int          nv, dcyc, dcnt;

    seq_pattern_tx_if #(.PAT_W(4), .CNT_W(4)) bus ();

    seq_pattern_tx #(.PAT_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Start pulse at edge k, then sample n cycles (cycle 1 follows edge k) at the falling edge.
    // stop_at raises stop during that cycle; dist_at pokes start and new config during that cycle.
    task automatic run(input logic [3:0] p, input logic [3:0] r, input logic [3:0] g,
                       input int n, input int stop_at, input int dist_at);
        @(negedge clk);
        bus.pattern  = p;
        bus.repeat_n = r;
        bus.gap      = g;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        xs = '0; vs = '0; ds = '0; bs = '0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            xs = {xs[30:0], bus.x};
            vs = {vs[30:0], bus.bit_valid};
            ds = {ds[30:0], bus.done};
            bs = {bs[30:0], bus.busy};
            bus.stop = (i == stop_at);
            if (i == dist_at) begin
                bus.start    = 1'b1;
                bus.pattern  = ~p;
                bus.repeat_n = 4'd1;
                bus.gap      = 4'd0;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.pattern  = '0;
        bus.repeat_n = '0;
        bus.gap      = '0;
        #2;
        chk("reset_outs", {28'd0, bus.x, bus.bit_valid, bus.busy, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // back-to-back: 1010 x3, gap 0
        run(4'b1010, 4'd3, 4'd0, 14, 0, 0);
        chk("b2b_x",    xs, 32'b10101010101000);
        chk("b2b_vld",  vs, 32'b11111111111100);
        chk("b2b_done", ds, 32'b00000000000010);
        chk("b2b_busy", bs, 32'b11111111111110);

        // gaps: 1101 x2, gap 2
        run(4'b1101, 4'd2, 4'd2, 12, 0, 0);
        chk("gap_x",    xs, 32'b110100110100);
        chk("gap_vld",  vs, 32'b111100111100);
        chk("gap_done", ds, 32'b000000000010);
        chk("gap_busy", bs, 32'b111111111110);

        // zero repeats
        run(4'b1111, 4'd0, 4'd0, 3, 0, 0);
        chk("zero_vld",  vs, 32'b000);
        chk("zero_done", ds, 32'b100);
        chk("zero_busy", bs, 32'b100);

        // stop and start together in IDLE: stop wins
        @(negedge clk);
        bus.pattern  = 4'b1111;
        bus.repeat_n = 4'd1;
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.stop = 1'b0;
        @(negedge clk);
        chk("stop_start_idle_busy", 32'(bus.busy), 32'd0);

        // abort during 3rd bit of repetition 2 (cycle 7)
        run(4'b1011, 4'd3, 4'd0, 12, 7, 0);
        chk("abort_x",    xs, 32'b101110100000);
        chk("abort_vld",  vs, 32'b111111100000);
        chk("abort_done", ds, 32'b000000000000);
        chk("abort_busy", bs, 32'b111111100000);

        // new start accepted after abort
        run(4'b0110, 4'd1, 4'd0, 6, 0, 0);
        chk("post_abort_x",    xs, 32'b011000);
        chk("post_abort_done", ds, 32'b000010);

        // start and config change while busy must not disturb the frame
        run(4'b1101, 4'd2, 4'd2, 12, 0, 3);
        chk("ign_send_x",    xs, 32'b110100110100);
        chk("ign_send_vld",  vs, 32'b111100111100);
        chk("ign_send_done", ds, 32'b000000000010);
        run(4'b1101, 4'd2, 4'd2, 12, 0, 6);
        chk("ign_gap_x",    xs, 32'b110100110100);
        chk("ign_gap_done", ds, 32'b000000000010);

        // maximum repeat count: 15 reps of 4 bits, no wrap
        @(negedge clk);
        bus.pattern  = 4'b1001;
        bus.repeat_n = 4'd15;
        bus.gap      = 4'd0;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        nv = 0; dcyc = 0; dcnt = 0;
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk);
            if (bus.bit_valid) nv++;
            if (bus.done) begin
                dcnt++;
                if (dcyc == 0) dcyc = i;
            end
        end
        chk("max_rep_bits",  32'(nv),   32'd60);
        chk("max_rep_dcyc",  32'(dcyc), 32'd61);
        chk("max_rep_dcnt",  32'(dcnt), 32'd1);

        // async reset in the middle of a GAP cycle
        @(negedge clk);
        bus.pattern  = 4'b1101;
        bus.repeat_n = 4'd2;
        bus.gap      = 4'd2;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("pre_reset_in_gap", {28'd0, bus.x, bus.bit_valid, bus.busy, bus.done}, 32'b0010);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_outs", {28'd0, bus.x, bus.bit_valid, bus.busy, bus.done}, 32'd0);
        ds = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ds = {ds[30:0], bus.done | bus.busy};
        end
        chk("reset_hold_quiet", ds, 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // start accepted on the first edge after reset release
        run(4'b1100, 4'd1, 4'd0, 6, 0, 0);
        chk("post_reset_x",    xs, 32'b110000);
        chk("post_reset_done", ds, 32'b000010);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
